csa_resolve: RTL and testbench

Sequential carry-propagate resolver for the CSA tree's output. Takes a redundant sum/carry pair as produced by a `carry_save_adder` stage (S plus raw Cout vector) and converts it to a plain binary sum. It resolves SEG_LEN bits per cycle, registering the carry between segments. It sits at the tail of CSA-based multipliers and accumulators, behind a valid/ready handshake on both sides.

---
 rtl/csa_pkg.sv | 15 +
 rtl/carry_propagate_segment.sv | 14 +
 rtl/csa_resolve.sv | 97 +++++++++
 tb/tb_csa_resolve.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the sequential CSA carry resolver.
package csa_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic int num_segs(input int bit_len, input int seg_len);
    return (bit_len + 2 + seg_len - 1) / seg_len;
  endfunction

  // Segment counter needs at least one bit even when a single segment covers the word.
  function automatic int seg_cnt_width(input int n_segs);
    return (n_segs > 1) ? $clog2(n_segs) : 1;
  endfunction

endpackage

// File: rtl/carry_propagate_segment.sv
// Combinational SEG_LEN-bit ripple adder; one slice of the resolver's carry chain.
module carry_propagate_segment #(
  parameter int SEG_LEN = 16
) (
  input  logic [SEG_LEN-1:0] A,
  input  logic [SEG_LEN-1:0] B,
  input  logic               Cin,
  output logic [SEG_LEN-1:0] S,
  output logic               Cout
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {{SEG_LEN{1'b0}}, Cin};

endmodule

// File: rtl/csa_resolve.sv
// Converts a redundant CSA sum/carry pair into a binary sum, resolving SEG_LEN
// bits per cycle with the carry registered between segments.
module csa_resolve
  import csa_pkg::*;
#(
  parameter int BIT_LEN = 64,
  parameter int SEG_LEN = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] in_s,
  input  logic [BIT_LEN-1:0] in_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN+1:0] out_sum
);

  localparam int NUM_SEGS = num_segs(BIT_LEN, SEG_LEN);
  localparam int W        = NUM_SEGS * SEG_LEN;
  localparam int CW       = seg_cnt_width(NUM_SEGS);
  localparam logic [CW-1:0] LAST_SEG = CW'(NUM_SEGS - 1);

  state_t state, next_state;

  logic [W-1:0]       a_reg, b_reg, result;
  logic [CW-1:0]      seg_cnt;
  logic               carry;
  int                 seg_base;
  logic [SEG_LEN-1:0] seg_a, seg_b, seg_sum;
  logic               seg_cout;

  always_comb begin
    seg_base = int'(seg_cnt) * SEG_LEN;
    seg_a    = a_reg[seg_base +: SEG_LEN];
    seg_b    = b_reg[seg_base +: SEG_LEN];
  end

  carry_propagate_segment #(.SEG_LEN(SEG_LEN)) u_seg (
    .A   (seg_a),
    .B   (seg_b),
    .Cin (carry),
    .S   (seg_sum),
    .Cout(seg_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)             next_state = BUSY;
      BUSY:    if (seg_cnt == LAST_SEG)  next_state = DONE;
      DONE:    if (out_ready)            next_state = IDLE;
      default:                           next_state = IDLE;
    endcase
  end

  // The carry out of the top segment is always zero, so it is simply never consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      result  <= '0;
      seg_cnt <= '0;
      carry   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= W'(in_s);
            b_reg   <= W'({in_c, 1'b0});
            seg_cnt <= '0;
            carry   <= 1'b0;
          end
        end
        BUSY: begin
          result[seg_base +: SEG_LEN] <= seg_sum;
          carry   <= seg_cout;
          seg_cnt <= (seg_cnt == LAST_SEG) ? '0 : seg_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    out_sum   = result[BIT_LEN+1:0];
  end

endmodule

// File: tb/tb_csa_resolve.sv
// Directed and random checks of csa_resolve at 64/16 and 19/8 configurations.
module tb_csa_resolve;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v64_in_valid, v64_in_ready, v64_out_valid, v64_out_ready;
  logic [63:0] v64_in_s, v64_in_c;
  logic [65:0] v64_out_sum;
  logic        v19_in_valid, v19_in_ready, v19_out_valid, v19_out_ready;
  logic [18:0] v19_in_s, v19_in_c;
  logic [20:0] v19_out_sum;

  int checks = 0;
  int errors = 0;

  csa_resolve #(.BIT_LEN(64), .SEG_LEN(16)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(v64_in_valid), .in_ready(v64_in_ready),
    .in_s(v64_in_s), .in_c(v64_in_c),
    .out_valid(v64_out_valid), .out_ready(v64_out_ready),
    .out_sum(v64_out_sum)
  );

  csa_resolve #(.BIT_LEN(19), .SEG_LEN(8)) dut19 (
    .clk(clk), .reset(reset),
    .in_valid(v19_in_valid), .in_ready(v19_in_ready),
    .in_s(v19_in_s), .in_c(v19_in_c),
    .out_valid(v19_out_valid), .out_ready(v19_out_ready),
    .out_sum(v19_out_sum)
  );

  // Issue one operation, scramble the inputs after the accept edge, and
  // report the resolved sum and the cycles from accept to out_valid.
  task automatic run64(input logic [63:0] s, input logic [63:0] c,
                       output logic [65:0] sum, output int lat);
    @(negedge clk);
    v64_in_s = s; v64_in_c = c; v64_in_valid = 1'b1;
    @(negedge clk);
    v64_in_valid = 1'b0; v64_in_s = ~s; v64_in_c = ~c;
    lat = 0;
    while (!v64_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    sum = v64_out_sum;
    v64_out_ready = 1'b1;
    @(negedge clk);
    v64_out_ready = 1'b0;
  endtask

  task automatic run19(input logic [18:0] s, input logic [18:0] c,
                       output logic [20:0] sum, output int lat);
    @(negedge clk);
    v19_in_s = s; v19_in_c = c; v19_in_valid = 1'b1;
    @(negedge clk);
    v19_in_valid = 1'b0; v19_in_s = ~s; v19_in_c = ~c;
    lat = 0;
    while (!v19_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    sum = v19_out_sum;
    v19_out_ready = 1'b1;
    @(negedge clk);
    v19_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (v64_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready64: got %b expected 1", v64_in_ready); end
    checks++; if (v64_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid64: got %b expected 0", v64_out_valid); end
    checks++; if (v64_out_sum !== 66'h0) begin errors++; $display("[TB] FAIL reset_out_sum64: got %h expected 0", v64_out_sum); end
    checks++; if (v19_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready19: got %b expected 1", v19_in_ready); end
    checks++; if (v19_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid19: got %b expected 0", v19_out_valid); end
    reset = 1'b0;
  endtask

  task automatic test_basic64();
    logic [65:0] sum;
    int lat;
    run64(64'h0, 64'h0, sum, lat);
    checks++; if (sum !== 66'h0) begin errors++; $display("[TB] FAIL zero_sum: got %h expected 0", sum); end
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected 5", lat); end
    run64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, sum, lat);
    checks++; if (sum !== 66'h1_0000_0000_0000_0001) begin errors++; $display("[TB] FAIL ripple_sum: got %h expected 10000000000000001", sum); end
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL ripple_latency: got %0d expected 5", lat); end
    run64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, sum, lat);
    checks++; if (sum !== 66'h2_FFFF_FFFF_FFFF_FFFD) begin errors++; $display("[TB] FAIL top_bits_sum: got %h expected 2fffffffffffffffd", sum); end
    run64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, sum, lat);
    checks++; if (sum !== 66'h1_8000_0000_0000_0000) begin errors++; $display("[TB] FAIL msb_sum: got %h expected 18000000000000000", sum); end
    run64(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_8000, sum, lat);
    checks++; if (sum !== 66'h0_0000_0000_0001_FFFF) begin errors++; $display("[TB] FAIL seg_carry_sum: got %h expected 1ffff", sum); end
    checks++; if (v64_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_after_handshake: got %b expected 1", v64_in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    v64_in_s = 64'h0000_0000_0000_00FF; v64_in_c = 64'h1; v64_in_valid = 1'b1;
    @(negedge clk);
    // Next operands are presented immediately and held while the block is busy.
    v64_in_s = 64'hFFFF_0000_0000_0000; v64_in_c = 64'h0000_8000_0000_0000;
    lat = 0;
    while (!v64_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL bp_latency1: got %0d expected 5", lat); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (v64_out_sum !== 66'h101) begin errors++; $display("[TB] FAIL bp_hold_sum: cycle %0d got %h expected 101", i, v64_out_sum); end
      checks++; if (v64_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: cycle %0d got %b expected 0", i, v64_in_ready); end
      checks++; if (v64_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid: cycle %0d got %b expected 1", i, v64_out_valid); end
      @(negedge clk);
    end
    v64_out_ready = 1'b1;
    @(negedge clk);
    v64_out_ready = 1'b0;
    checks++; if (v64_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_after: got %b expected 1", v64_in_ready); end
    checks++; if (v64_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_after: got %b expected 0", v64_out_valid); end
    @(negedge clk);
    v64_in_valid = 1'b0; v64_in_s = 64'h0; v64_in_c = 64'h0;
    checks++; if (v64_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_second_accept: got %b expected 0", v64_in_ready); end
    lat = 0;
    while (!v64_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL bp_latency2: got %0d expected 5", lat); end
    checks++; if (v64_out_sum !== 66'h1_0000_0000_0000_0000) begin errors++; $display("[TB] FAIL bp_second_sum: got %h expected 10000000000000000", v64_out_sum); end
    v64_out_ready = 1'b1;
    @(negedge clk);
    v64_out_ready = 1'b0;
  endtask

  task automatic test_reset_busy();
    int pulses;
    @(negedge clk);
    v64_in_s = 64'h0000_0000_1234_5678; v64_in_c = 64'h0; v64_in_valid = 1'b1;
    @(negedge clk);
    v64_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    // Two segments have been written; reset lands while seg_cnt is 2.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (v64_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL busy_reset_valid: got %b expected 0", v64_out_valid); end
    checks++; if (v64_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL busy_reset_ready: got %b expected 1", v64_in_ready); end
    checks++; if (v64_out_sum !== 66'h0) begin errors++; $display("[TB] FAIL busy_reset_sum: got %h expected 0", v64_out_sum); end
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (v64_out_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL busy_reset_no_output: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_small_config();
    logic [20:0] sum;
    logic [20:0] expected;
    logic [18:0] s, c;
    int lat;
    run19(19'h7FFFF, 19'h40000, sum, lat);
    checks++; if (sum !== 21'h0FFFFF) begin errors++; $display("[TB] FAIL small_sum: got %h expected 0fffff", sum); end
    checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL small_latency: got %0d expected 3", lat); end
    run19(19'h7FFFF, 19'h7FFFF, sum, lat);
    checks++; if (sum !== 21'h17FFFD) begin errors++; $display("[TB] FAIL small_top_bits: got %h expected 17fffd", sum); end
    for (int i = 0; i < 500; i++) begin
      s = 19'($urandom);
      c = 19'($urandom);
      expected = {2'b00, s} + {1'b0, c, 1'b0};
      run19(s, c, sum, lat);
      checks++; if (sum !== expected) begin errors++; $display("[TB] FAIL small_random: s=%h c=%h got %h expected %h", s, c, sum, expected); end
    end
  endtask

  initial begin
    reset = 1'b1;
    v64_in_valid = 1'b0; v64_out_ready = 1'b0; v64_in_s = '0; v64_in_c = '0;
    v19_in_valid = 1'b0; v19_out_ready = 1'b0; v19_in_s = '0; v19_in_c = '0;
    test_reset();
    test_basic64();
    test_back_to_back();
    test_reset_busy();
    test_small_config();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
